// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - reconstructs per-digit values from a scanned 7-segment display bus
module seg_scan_capture #(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   digit_sel,
   input  logic [7:0]              seg_data,
   output logic                    digit_valid,
   output logic [2:0]              digit_idx,
   output logic [3:0]              digit_val,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   dp_out,
   output logic                    frame_valid,
   output logic                    frame_err,
   output logic [15:0]             frame_cnt
);

   typedef enum logic {S_TRACK, S_HELD} state_t;

   state_t                  r_state, w_state_next;
   logic [NUM_DIGITS-1:0]   r_sel;
   logic [7:0]              r_seg;
   logic [7:0]              r_cnt, w_cnt_next;
   logic [4*NUM_DIGITS-1:0] r_shadow, w_shadow_m;
   logic [NUM_DIGITS-1:0]   r_shadow_dp, w_dp_m;
   logic [NUM_DIGITS-1:0]   r_seen, w_seen_m;
   logic                    r_digit_valid, r_frame_valid, r_frame_err;
   logic [2:0]              r_digit_idx, w_idx;
   logic [3:0]              r_digit_val, w_dec;
   logic [4*NUM_DIGITS-1:0] r_digits_out;
   logic [NUM_DIGITS-1:0]   r_dp_out;
   logic [15:0]             r_frame_cnt;
   logic                    w_stable, w_capture, w_frame_done, w_any_err;

   assign w_stable = ({digit_sel, seg_data} == {r_sel, r_seg}) && $onehot(digit_sel);

   // Saturating so a long hold in HELD never wraps back onto STABLE_CYCLES.
   always_comb begin
      w_cnt_next = 8'd0;
      if (w_stable)
         w_cnt_next = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
   end

   always_comb begin
      w_dec = 4'hE;
      case (seg_data[7:1])
         7'h7E: w_dec = 4'h0;
         7'h30: w_dec = 4'h1;
         7'h6D: w_dec = 4'h2;
         7'h79: w_dec = 4'h3;
         7'h33: w_dec = 4'h4;
         7'h5B: w_dec = 4'h5;
         7'h5F: w_dec = 4'h6;
         7'h70: w_dec = 4'h7;
         7'h7F: w_dec = 4'h8;
         7'h73: w_dec = 4'h9;
         7'h00: w_dec = 4'hF;
         default: w_dec = 4'hE;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      case (r_state)
         S_TRACK: begin
            if (w_stable && (w_cnt_next == 8'(STABLE_CYCLES))) begin
               w_capture    = 1'b1;
               w_state_next = S_HELD;
            end
         end
         S_HELD: begin
            if (!w_stable)
               w_state_next = S_TRACK;
         end
         default: w_state_next = S_TRACK;
      endcase
   end

   // Shadow contents with the current digit merged in, so a completing capture
   // publishes its own nibble on the same edge.
   always_comb begin
      w_idx      = 3'd0;
      w_shadow_m = r_shadow;
      w_dp_m     = r_shadow_dp;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_sel[i]) begin
            w_idx              = 3'(i);
            w_shadow_m[4*i +: 4] = w_dec;
            w_dp_m[i]          = seg_data[0];
         end
      end
      w_seen_m     = r_seen | digit_sel;
      w_frame_done = w_capture && (&w_seen_m);
      w_any_err    = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (w_shadow_m[4*i +: 4] == 4'hE)
            w_any_err = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_TRACK;
         r_sel         <= '0;
         r_seg         <= 8'd0;
         r_cnt         <= 8'd0;
         r_shadow      <= '1;
         r_shadow_dp   <= '0;
         r_seen        <= '0;
         r_digit_valid <= 1'b0;
         r_digit_idx   <= 3'd0;
         r_digit_val   <= 4'd0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_frame_cnt   <= 16'd0;
         r_digits_out  <= '1;
         r_dp_out      <= '0;
      end else begin
         r_state       <= w_state_next;
         r_sel         <= digit_sel;
         r_seg         <= seg_data;
         r_cnt         <= w_cnt_next;
         r_digit_valid <= w_capture;
         r_frame_valid <= w_frame_done;
         if (w_capture) begin
            r_digit_idx <= w_idx;
            r_digit_val <= w_dec;
            r_shadow    <= w_shadow_m;
            r_shadow_dp <= w_dp_m;
            r_seen      <= w_frame_done ? '0 : w_seen_m;
         end
         if (w_frame_done) begin
            r_digits_out <= w_shadow_m;
            r_dp_out     <= w_dp_m;
            r_frame_err  <= w_any_err;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign digit_valid = r_digit_valid;
   assign digit_idx   = r_digit_idx;
   assign digit_val   = r_digit_val;
   assign digits_out  = r_digits_out;
   assign dp_out      = r_dp_out;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - scoreboard bench for seg_scan_capture
module tb_seg_scan_capture;
   localparam int N = 8;
   localparam int S = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  digit_sel;
   logic [7:0]    seg_data;
   logic          digit_valid, frame_valid, frame_err;
   logic [2:0]    digit_idx;
   logic [3:0]    digit_val;
   logic [4*N-1:0] digits_out;
   logic [N-1:0]  dp_out;
   logic [15:0]   frame_cnt;

   seg_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .digit_sel(digit_sel), .seg_data(seg_data),
      .digit_valid(digit_valid), .digit_idx(digit_idx), .digit_val(digit_val),
      .digits_out(digits_out), .dp_out(dp_out), .frame_valid(frame_valid),
      .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int edges = 0;

   logic [7:0] pats [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};

   // expectation queues
   int            dq_idx[$];
   logic [3:0]    dq_val[$];
   int            dq_e[$];
   logic [4*N-1:0] fq_dig[$];
   logic [N-1:0]  fq_dp[$];
   logic          fq_err[$];
   logic [15:0]   fq_cnt[$];
   int            fq_e[$];

   // reference model state
   logic [N-1:0]  m_prev_sel;
   logic [7:0]    m_prev_seg;
   int            m_run;
   logic [3:0]    m_shadow[N];
   logic          m_dp[N];
   logic [N-1:0]  m_seen;
   logic [15:0]   m_fcnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] decode(input logic [7:0] seg);
      logic [7:0] m;
      m = seg & 8'hFE;
      if (m == 8'h00) return 4'hF;
      for (int i = 0; i < 10; i++)
         if (pats[i] == m) return 4'(i);
      return 4'hE;
   endfunction

   task automatic model_reset();
      m_run  = 0;
      m_prev_sel = '0;
      m_prev_seg = '0;
      m_seen = '0;
      m_fcnt = 16'd0;
      for (int i = 0; i < N; i++) begin
         m_shadow[i] = 4'hF;
         m_dp[i] = 1'b0;
      end
   endtask

   task automatic model_capture(input int e, input logic [N-1:0] sel, input logic [7:0] seg);
      int idx;
      logic [4*N-1:0] dig;
      logic [N-1:0] dp;
      logic err;
      idx = 0;
      for (int i = 0; i < N; i++) if (sel[i]) idx = i;
      dq_idx.push_back(idx);
      dq_val.push_back(decode(seg));
      dq_e.push_back(e);
      m_shadow[idx] = decode(seg);
      m_dp[idx] = seg[0];
      m_seen[idx] = 1'b1;
      if (&m_seen) begin
         err = 1'b0;
         for (int i = 0; i < N; i++) begin
            dig[4*i +: 4] = m_shadow[i];
            dp[i] = m_dp[i];
            if (m_shadow[i] == 4'hE) err = 1'b1;
         end
         m_fcnt = m_fcnt + 16'd1;
         m_seen = '0;
         fq_dig.push_back(dig);
         fq_dp.push_back(dp);
         fq_err.push_back(err);
         fq_cnt.push_back(m_fcnt);
         fq_e.push_back(e);
      end
   endtask

   // Present one sample for the next edge; a capture is due on the (S+1)th identical one-hot sample.
   task automatic drive(input logic [N-1:0] sel, input logic [7:0] seg, input int n);
      for (int k = 0; k < n; k++) begin
         digit_sel = sel;
         seg_data  = seg;
         if (m_run > 0 && sel == m_prev_sel && seg == m_prev_seg) m_run++;
         else m_run = 1;
         m_prev_sel = sel;
         m_prev_seg = seg;
         if ($countones(sel) == 1 && m_run == S + 1)
            model_capture(edges + 1, sel, seg);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_digits"}, digits_out, {N{4'hF}});
      check({tag, "_dp"}, dp_out, 0);
      check({tag, "_dvalid"}, digit_valid, 0);
      check({tag, "_idx"}, digit_idx, 0);
      check({tag, "_val"}, digit_val, 0);
      check({tag, "_fvalid"}, frame_valid, 0);
      check({tag, "_ferr"}, frame_err, 0);
      check({tag, "_fcnt"}, frame_cnt, 0);
   endtask

   // monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (digit_valid) begin
               if (dq_idx.size() == 0) begin
                  check("unexpected_digit_valid", 1, 0);
               end else begin
                  check("digit_idx", digit_idx, dq_idx[0]);
                  check("digit_val", digit_val, dq_val[0]);
                  check("digit_edge", edges, dq_e[0]);
                  void'(dq_idx.pop_front()); void'(dq_val.pop_front()); void'(dq_e.pop_front());
               end
            end
            while (dq_e.size() > 0 && dq_e[0] < edges) begin
               check("missing_digit_valid", 0, 1);
               void'(dq_idx.pop_front()); void'(dq_val.pop_front()); void'(dq_e.pop_front());
            end
            if (frame_valid) begin
               if (fq_e.size() == 0) begin
                  check("unexpected_frame_valid", 1, 0);
               end else begin
                  check("frame_digits", digits_out, fq_dig[0]);
                  check("frame_dp", dp_out, fq_dp[0]);
                  check("frame_err", frame_err, fq_err[0]);
                  check("frame_cnt", frame_cnt, fq_cnt[0]);
                  check("frame_edge", edges, fq_e[0]);
                  void'(fq_dig.pop_front()); void'(fq_dp.pop_front()); void'(fq_err.pop_front());
                  void'(fq_cnt.pop_front()); void'(fq_e.pop_front());
               end
            end
            while (fq_e.size() > 0 && fq_e[0] < edges) begin
               check("missing_frame_valid", 0, 1);
               void'(fq_dig.pop_front()); void'(fq_dp.pop_front()); void'(fq_err.pop_front());
               void'(fq_cnt.pop_front()); void'(fq_e.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         edges++;
      end
   end

   initial begin
      logic [N-1:0] sel;
      logic [7:0] seg;
      rst = 1'b1;
      digit_sel = '0;
      seg_data = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // 1..8 scan with blanks
      for (int d = 0; d < N; d++) begin
         drive(N'(1) << d, pats[d + 1], 10);
         drive('0, 8'h00, 2);
      end
      check("scan_digits", digits_out, 32'h87654321);
      check("scan_err", frame_err, 0);
      check("scan_cnt", frame_cnt, 1);

      // short dwell, then a long one
      drive(N'(1), pats[3], 3);
      drive('0, 8'h00, 2);
      drive(N'(1), pats[3], 50);
      drive('0, 8'h00, 2);

      // dp-only blank digit and undecodable digit
      for (int d = 0; d < N; d++) begin
         seg = (d == 2) ? 8'h01 : (d == 5) ? 8'h4A : 8'hFC;
         drive(N'(1) << d, seg, 8);
         drive('0, 8'h00, 2);
      end
      check("blank_nibble2", digits_out[11:8], 4'hF);
      check("dp2", dp_out[2], 1);
      check("err_nibble5", digits_out[23:20], 4'hE);
      check("frame_err_set", frame_err, 1);

      // multi-bit select, then glitch mid-dwell
      drive(N'(3), pats[5], 20);
      drive(N'(8), pats[5], 2);
      drive(N'(8), pats[5] | 8'h01, 1);
      drive(N'(8), pats[5], 10);
      drive('0, 8'h00, 2);

      // reset after five captures of a frame
      for (int d = 0; d < 5; d++) begin
         drive(N'(1) << d, pats[9 - d], 7);
         drive('0, 8'h00, 2);
      end
      rst = 1'b1;
      #1;
      check_reset_outputs("midframe_reset");
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int d = 0; d < N; d++) begin
         drive(N'(1) << d, pats[d], 6);
         drive('0, 8'h00, 1);
      end
      check("post_reset_cnt", frame_cnt, 1);

      // counter wrap
      force dut.r_frame_cnt = 16'hFFFF;
      drive('0, 8'h00, 1);
      release dut.r_frame_cnt;
      m_fcnt = 16'hFFFF;
      for (int d = 0; d < N; d++) begin
         drive(N'(1) << d, pats[(d * 3) % 10] | 8'(d & 1), 6);
         drive('0, 8'h00, 1);
      end
      check("wrap_cnt", frame_cnt, 0);

      // randomized scanning
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 9) == 0) sel = N'($urandom_range(0, 255));
         else sel = N'(1) << $urandom_range(0, N - 1);
         if ($urandom_range(0, 7) == 0) seg = 8'($urandom_range(0, 255));
         else seg = pats[$urandom_range(0, 9)] | 8'($urandom_range(0, 1));
         drive(sel, seg, $urandom_range(1, 9));
         if ($urandom_range(0, 4) == 0)
            drive(sel, seg ^ 8'h80, 1);
         drive('0, 8'h00, $urandom_range(0, 2));
      end

      drive('0, 8'h00, 10);
      check("digit_q_drained", dq_e.size(), 0);
      check("frame_q_drained", fq_e.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
